// File: rtl/dds_param_ctrl.sv
// Button-driven DDS parameter controller: edits shadow registers and commits them atomically via req/ack.
// Optional auto-repeat on held up/down buttons is enabled with `define DDS_AUTOREPEAT_EN.
module dds_param_ctrl #(
  parameter int unsigned PHASE_W    = 12,
  parameter int unsigned AMP_W      = 11,
  parameter int unsigned AMP_MAX    = 2047,
  parameter int unsigned PHASE_RST  = 500,
  parameter int unsigned AMP_RST    = 1200,
  parameter int unsigned PHASE_STEP = 10,
  parameter int unsigned AMP_STEP   = 50,
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_CYC = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_sel,
  input  logic               upd_ack,
  output logic [PHASE_W-1:0] phase_M,
  output logic [AMP_W-1:0]   signal_A,
  output logic [1:0]         signal_shape,
  output logic [1:0]         edit_field,
  output logic               upd_req
);

  localparam int unsigned PW1    = PHASE_W + 1;
  localparam int unsigned AW1    = AMP_W + 1;
  localparam int unsigned PH_MAX = (2 ** PHASE_W) - 1;

  typedef enum logic [1:0] {
    F_FREQ  = 2'd0,
    F_AMP   = 2'd1,
    F_SHAPE = 2'd2
  } field_e;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_REQ  = 1'b1
  } commit_e;

  logic up_q, up_p_q, dn_q, dn_p_q, sel_q, sel_p_q;
  logic up_evt, dn_evt, sel_evt, do_up, do_dn;

  field_e  field_q;
  commit_e commit_q;
  logic    upd_req_q;

  logic [PHASE_W-1:0] ph_q, ph_sh_q, ph_sh_d;
  logic [AMP_W-1:0]   amp_q, amp_sh_q, amp_sh_d;
  logic [1:0]         shp_q, shp_sh_q, shp_sh_d;
  logic [PW1-1:0]     ph_sum;
  logic [AW1-1:0]     amp_sum;
  logic               dirty;

  assign sel_evt = sel_q & ~sel_p_q;

`ifdef DDS_AUTOREPEAT_EN
  localparam int unsigned CNT_W = 25;

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_held, rpt_fire;

  // Hold counter: first repeat at REPEAT_DLY, then reload so it recurs every REPEAT_CYC
  always_comb begin
    rpt_held  = up_q | dn_q;
    rpt_fire  = 1'b0;
    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
    if (!rpt_held || sel_evt) begin
      rpt_cnt_d = '0;
    end else if (rpt_cnt_q == CNT_W'(REPEAT_DLY)) begin
      rpt_fire  = 1'b1;
      rpt_cnt_d = CNT_W'(REPEAT_DLY - REPEAT_CYC + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rpt_cnt_q <= '0;
    else     rpt_cnt_q <= rpt_cnt_d;
  end

  assign up_evt = (up_q & ~up_p_q) | (up_q & rpt_fire);
  assign dn_evt = (dn_q & ~dn_p_q) | (dn_q & rpt_fire);
`else
  assign up_evt = up_q & ~up_p_q;
  assign dn_evt = dn_q & ~dn_p_q;
`endif

  // sel beats up/down; simultaneous up and down cancel
  assign do_up = up_evt & ~dn_evt & ~sel_evt;
  assign do_dn = dn_evt & ~up_evt & ~sel_evt;

  // Saturating shadow arithmetic for the field being edited
  always_comb begin
    ph_sh_d  = ph_sh_q;
    amp_sh_d = amp_sh_q;
    shp_sh_d = shp_sh_q;
    ph_sum   = PW1'(ph_sh_q) + PW1'(PHASE_STEP);
    amp_sum  = AW1'(amp_sh_q) + AW1'(AMP_STEP);
    case (field_q)
      F_FREQ: begin
        if (do_up) begin
          ph_sh_d = (ph_sum > PW1'(PH_MAX)) ? PHASE_W'(PH_MAX) : ph_sum[PHASE_W-1:0];
        end else if (do_dn) begin
          ph_sh_d = (ph_sh_q <= PHASE_W'(PHASE_STEP)) ? PHASE_W'(1)
                                                       : ph_sh_q - PHASE_W'(PHASE_STEP);
        end
      end
      F_AMP: begin
        if (do_up) begin
          amp_sh_d = (amp_sum > AW1'(AMP_MAX)) ? AMP_W'(AMP_MAX) : amp_sum[AMP_W-1:0];
        end else if (do_dn) begin
          amp_sh_d = (amp_sh_q < AMP_W'(AMP_STEP)) ? '0 : amp_sh_q - AMP_W'(AMP_STEP);
        end
      end
      F_SHAPE: begin
        if (do_up) begin
          shp_sh_d = (shp_sh_q >= 2'd2) ? 2'd0 : shp_sh_q + 2'd1;
        end else if (do_dn) begin
          shp_sh_d = (shp_sh_q == 2'd0) ? 2'd2 : shp_sh_q - 2'd1;
        end
      end
      default: ;
    endcase
    dirty = (ph_sh_q != ph_q) | (amp_sh_q != amp_q) | (shp_sh_q != shp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q      <= 1'b0;
      up_p_q    <= 1'b0;
      dn_q      <= 1'b0;
      dn_p_q    <= 1'b0;
      sel_q     <= 1'b0;
      sel_p_q   <= 1'b0;
      field_q   <= F_FREQ;
      commit_q  <= C_IDLE;
      upd_req_q <= 1'b0;
      ph_q      <= PHASE_W'(PHASE_RST);
      ph_sh_q   <= PHASE_W'(PHASE_RST);
      amp_q     <= AMP_W'(AMP_RST);
      amp_sh_q  <= AMP_W'(AMP_RST);
      shp_q     <= 2'd0;
      shp_sh_q  <= 2'd0;
    end else begin
      up_q     <= btn_up;
      up_p_q   <= up_q;
      dn_q     <= btn_down;
      dn_p_q   <= dn_q;
      sel_q    <= btn_sel;
      sel_p_q  <= sel_q;
      ph_sh_q  <= ph_sh_d;
      amp_sh_q <= amp_sh_d;
      shp_sh_q <= shp_sh_d;

      if (sel_evt) begin
        case (field_q)
          F_FREQ:  field_q <= F_AMP;
          F_AMP:   field_q <= F_SHAPE;
          default: field_q <= F_FREQ;
        endcase
      end

      // Applied values load from the pre-edge shadows only on the ack edge
      case (commit_q)
        C_IDLE: begin
          if (dirty) begin
            commit_q  <= C_REQ;
            upd_req_q <= 1'b1;
          end
        end
        C_REQ: begin
          if (upd_ack) begin
            ph_q      <= ph_sh_q;
            amp_q     <= amp_sh_q;
            shp_q     <= shp_sh_q;
            upd_req_q <= 1'b0;
            commit_q  <= C_IDLE;
          end
        end
        default: begin
          commit_q  <= C_IDLE;
          upd_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign phase_M      = ph_q;
  assign signal_A     = amp_q;
  assign signal_shape = shp_q;
  assign edit_field   = field_q;
  assign upd_req      = upd_req_q;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Scoreboard bench for dds_param_ctrl: expected commits are queued by the stimulus, popped by a commit monitor.
module tb_dds_param_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, btn_sel, upd_ack;
  logic [11:0] phase_M;
  logic [10:0] signal_A;
  logic [1:0]  signal_shape, edit_field;
  logic        upd_req;

  typedef struct {
    int ph;
    int amp;
    int sh;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dds_param_ctrl #(.REPEAT_DLY(20), .REPEAT_CYC(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_sel      (btn_sel),
    .upd_ack      (upd_ack),
    .phase_M      (phase_M),
    .signal_A     (signal_A),
    .signal_shape (signal_shape),
    .edit_field   (edit_field),
    .upd_req      (upd_req)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int ph, input int amp, input int sh);
    exp_t e;
    e.ph = ph; e.amp = amp; e.sh = sh;
    exp_q.push_back(e);
  endtask

  // One-cycle button pulse, then enough idle cycles for a commit with ack high
  task automatic press(input logic u, input logic d, input logic s);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_sel = s;
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic count_req(input int ncyc, output int highs);
    highs = 0;
    repeat (ncyc) begin
      @(negedge clk);
      highs += int'(upd_req);
    end
  endtask

  // Commit monitor: a req&ack edge must load the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst && upd_req && upd_ack) begin
        #1;
        if (exp_q.size() == 0) begin
          check("unexpected_commit", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("commit_phase", int'(phase_M), e.ph);
          check("commit_amp", int'(signal_A), e.amp);
          check("commit_shape", int'(signal_shape), e.sh);
          check("commit_req_fall", int'(upd_req), 0);
        end
      end
    end
  end

  initial begin
    int cur, nxt, h, n_ev;
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; upd_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_phase", int'(phase_M), 500);
    check("rst_amp", int'(signal_A), 1200);
    check("rst_shape", int'(signal_shape), 0);
    check("rst_field", int'(edit_field), 0);
    check("rst_req", int'(upd_req), 0);

    // Frequency edit with cycle-exact latency
    @(negedge clk);
    push(510, 1200, 0);
    btn_up = 1'b1;
    @(negedge clk);
    btn_up = 1'b0;
    @(negedge clk);
    check("freq_req_n1", int'(upd_req), 0);
    @(negedge clk);
    check("freq_req_n2", int'(upd_req), 1);
    check("freq_hold_n2", int'(phase_M), 500);
    @(negedge clk);
    check("freq_phase_n3", int'(phase_M), 510);
    check("freq_req_n3", int'(upd_req), 0);
    repeat (3) @(negedge clk);
    push(500, 1200, 0); press(1'b0, 1'b1, 1'b0);
    push(490, 1200, 0); press(1'b0, 1'b1, 1'b0);
    push(480, 1200, 0); press(1'b0, 1'b1, 1'b0);
    check("freq_down3", int'(phase_M), 480);

    // Handshake stall: two edits while ack is low coalesce into one commit
    upd_ack = 1'b0;
    push(500, 1200, 0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    count_req(100, h);
    check("stall_req_held", h, 100);
    check("stall_phase_held", int'(phase_M), 480);
    upd_ack = 1'b1;
    @(negedge clk);
    check("ack_req_fall", int'(upd_req), 0);
    check("ack_phase", int'(phase_M), 500);

    // Priority: sel with up advances field only; up with down is discarded
    press(1'b1, 1'b0, 1'b1);
    check("sel_up_field", int'(edit_field), 1);
    check("sel_up_phase", int'(phase_M), 500);
    press(1'b1, 1'b1, 1'b0);
    check("up_down_amp", int'(signal_A), 1200);

    // Amplitude saturation at both ends
    cur = 1200;
    for (int i = 0; i < 30; i++) begin
      nxt = (cur + 50 > 2047) ? 2047 : cur + 50;
      if (nxt != cur) push(500, nxt, 0);
      cur = nxt;
      press(1'b1, 1'b0, 1'b0);
    end
    check("amp_ceiling", int'(signal_A), 2047);
    for (int i = 0; i < 50; i++) begin
      nxt = (cur < 50) ? 0 : cur - 50;
      if (nxt != cur) push(500, nxt, 0);
      cur = nxt;
      press(1'b0, 1'b1, 1'b0);
    end
    check("amp_floor", int'(signal_A), 0);

    // Shape cycling in both directions
    press(1'b0, 1'b0, 1'b1);
    check("shape_field", int'(edit_field), 2);
    push(500, 0, 1); press(1'b1, 1'b0, 1'b0);
    push(500, 0, 2); press(1'b1, 1'b0, 1'b0);
    push(500, 0, 0); press(1'b1, 1'b0, 1'b0);
    check("shape_up_wrap", int'(signal_shape), 0);
    push(500, 0, 2); press(1'b0, 1'b1, 1'b0);
    check("shape_down_wrap", int'(signal_shape), 2);
    push(500, 0, 1); press(1'b0, 1'b1, 1'b0);
    push(500, 0, 0); press(1'b0, 1'b1, 1'b0);

    // Tuning-word floor is 1, never 0
    press(1'b0, 1'b0, 1'b1);
    check("wrap_field", int'(edit_field), 0);
    cur = 500;
    for (int i = 0; i < 55; i++) begin
      nxt = (cur <= 10) ? 1 : cur - 10;
      if (nxt != cur) push(nxt, 0, 0);
      cur = nxt;
      press(1'b0, 1'b1, 1'b0);
    end
    check("phase_floor", int'(phase_M), 1);

    // Reset during a pending request drops it
    upd_ack = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    check("pend_req", int'(upd_req), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midreq_req", int'(upd_req), 0);
    check("midreq_phase", int'(phase_M), 500);
    check("midreq_amp", int'(signal_A), 1200);
    check("midreq_field", int'(edit_field), 0);
    upd_ack = 1'b1;
    count_req(10, h);
    check("midreq_no_reissue", h, 0);

    // Held up button: one event per press, plus repeats when enabled
`ifdef DDS_AUTOREPEAT_EN
    n_ev = 6;
`else
    n_ev = 1;
`endif
    for (int i = 1; i <= n_ev; i++) push(500 + 10 * i, 1200, 0);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (43) @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check("hold_events", int'(phase_M), 500 + 10 * n_ev);

    repeat (5) @(negedge clk);
    check("pending_commits", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
